// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - single-outstanding instruction fetch over an AXI4-Lite read master
// Optional IFU_FAULT_EN: adds fetch_fault, turns bad rresp / misaligned PC into an ebreak.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h80000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_next,
    input  logic        pc_write_enable,
    input  logic        ifu_receive_ready,
    output logic        ifu_send_valid,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready
`ifdef IFU_FAULT_EN
    ,
    output logic        fetch_fault
`endif
);

    localparam logic [31:0] EBREAK = 32'h00100073;

    typedef enum logic [1:0] {
        AR_REQ  = 2'd0,
        R_WAIT  = 2'd1,
        SEND    = 2'd2,
        WAIT_PC = 2'd3
    } state_t;

    state_t state;

    // Next PC is taken in WAIT_PC, or in SEND when the decode handshake lands the same cycle.
    logic take_pc;
    assign take_pc = pc_write_enable &&
                     ((state == WAIT_PC) || ((state == SEND) && ifu_receive_ready));

`ifdef IFU_FAULT_EN
    logic next_misaligned;
    logic cur_misaligned;
    logic bad_resp;
    assign next_misaligned = (pc_next[1:0] != 2'b00);
    assign cur_misaligned  = (pc[1:0] != 2'b00);
    assign bad_resp        = (rresp != 2'b00);
`else
    logic unused_rresp;
    assign unused_rresp = ^rresp;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= AR_REQ;
            pc             <= RESET_PC;
            araddr         <= RESET_PC;
            instruction    <= 32'h0;
            ifu_send_valid <= 1'b0;
            arvalid        <= 1'b0;
            rready         <= 1'b0;
`ifdef IFU_FAULT_EN
            fetch_fault    <= 1'b0;
`endif
        end else begin
            case (state)
                AR_REQ: begin
                    // arvalid is low only on the first cycle out of reset.
                    if (!arvalid) begin
`ifdef IFU_FAULT_EN
                        if (cur_misaligned) begin
                            instruction    <= EBREAK;
                            fetch_fault    <= 1'b1;
                            ifu_send_valid <= 1'b1;
                            state          <= SEND;
                        end else begin
                            arvalid <= 1'b1;
                            araddr  <= pc;
                        end
`else
                        arvalid <= 1'b1;
                        araddr  <= pc;
`endif
                    end else if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (rvalid) begin
                        instruction    <= rdata;
                        rready         <= 1'b0;
                        ifu_send_valid <= 1'b1;
                        state          <= SEND;
`ifdef IFU_FAULT_EN
                        if (bad_resp) begin
                            instruction <= EBREAK;
                            fetch_fault <= 1'b1;
                        end
`endif
                    end
                end
                SEND: begin
                    if (ifu_receive_ready) begin
                        ifu_send_valid <= 1'b0;
                        state          <= WAIT_PC;
`ifdef IFU_FAULT_EN
                        fetch_fault    <= 1'b0;
`endif
                    end
                end
                WAIT_PC: begin
                end
                default: state <= AR_REQ;
            endcase

            if (take_pc) begin
                pc     <= pc_next;
                araddr <= pc_next;
`ifdef IFU_FAULT_EN
                if (next_misaligned) begin
                    instruction    <= EBREAK;
                    fetch_fault    <= 1'b1;
                    ifu_send_valid <= 1'b1;
                    state          <= SEND;
                end else begin
                    arvalid <= 1'b1;
                    state   <= AR_REQ;
                end
`else
                arvalid <= 1'b1;
                state   <= AR_REQ;
`endif
            end
        end
    end

endmodule
